// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
// The build option SB_STALL_CNT_EN is consumed by issue_scoreboard and its interface.
package sb_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic       ready;
  } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// ID-stage request, retire/flush/load-completion events and scoreboard status.
// The stall_cycles signal exists only when SB_STALL_CNT_EN is defined.
interface issue_scoreboard_if #(
  parameter int DEPTH = sb_pkg::SB_DEPTH_DEFAULT
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_is_load;
  logic             mem_ld_done;
  logic             retire_valid;
  logic             flush;
  logic [PTR_W:0]   flush_cnt;
  logic             id_stall;
  logic             id_issue;
  logic [PTR_W:0]   inflight_cnt;
  logic             sb_full;
  logic             sb_empty;
  logic             sb_err;
`ifdef SB_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
    output id_reg_write, id_is_load, mem_ld_done, retire_valid, flush, flush_cnt,
    input  id_stall, id_issue, inflight_cnt, sb_full, sb_empty, sb_err
`ifdef SB_STALL_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
    input  id_reg_write, id_is_load, mem_ld_done, retire_valid, flush, flush_cnt,
    output id_stall, id_issue, inflight_cnt, sb_full, sb_empty, sb_err
`ifdef SB_STALL_CNT_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/issue_scoreboard_youngest_match.sv
// Finds the youngest in-flight writer of one source register and reports its readiness.
// Purely combinational; x0 never matches.
module sb_youngest_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [PTR_W-1:0] head_i,
  input  logic [PTR_W:0]   count_i,
  input  logic [4:0]       src_i,
  output logic             hit_o,
  output logic             hit_ready_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o       = 1'b0;
    hit_ready_o = 1'b0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_i) && (src_i != REG_X0) &&
          entries_i[idx].wr && (entries_i[idx].rd == src_i)) begin
        hit_o       = 1'b1;
        hit_ready_o = entries_i[idx].ready;
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: load-use stall detection, retire, branch-flush rollback.
// Define SB_STALL_CNT_EN to add the saturating stall_cycles counter.
module issue_scoreboard
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  issue_scoreboard_if.slave sb
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             hit1, hit1_ready, hit2, hit2_ready;
  logic             hazard, full, stall, issue;
  logic             ld_hit, retire_ok;
  logic [PTR_W-1:0] ld_idx, scan_idx, kill_idx;
  logic [PTR_W:0]   avail, kill;
  sb_entry_t        new_entry;

  sb_youngest_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .entries_i   (entries_q),
    .head_i      (head_q),
    .count_i     (cnt_q),
    .src_i       (sb.id_rs1),
    .hit_o       (hit1),
    .hit_ready_o (hit1_ready)
  );

  sb_youngest_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .entries_i   (entries_q),
    .head_i      (head_q),
    .count_i     (cnt_q),
    .src_i       (sb.id_rs2),
    .hit_o       (hit2),
    .hit_ready_o (hit2_ready)
  );

  assign hazard = (sb.id_use_rs1 & hit1 & ~hit1_ready) |
                  (sb.id_use_rs2 & hit2 & ~hit2_ready);
  assign full   = (cnt_q == DEPTH_C);
  assign stall  = sb.id_valid & (hazard | full);
  assign issue  = sb.id_valid & ~stall & ~sb.flush;

  assign new_entry.rd      = sb.id_rd;
  assign new_entry.wr      = sb.id_reg_write & (sb.id_rd != REG_X0);
  assign new_entry.is_load = sb.id_is_load;
  assign new_entry.ready   = ~sb.id_is_load;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_d     = err_q;
    ld_hit    = 1'b0;
    ld_idx    = '0;
    scan_idx  = '0;
    kill_idx  = '0;
    kill      = '0;

    // Youngest to oldest, so the final hit is the oldest pending load.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt_q) && entries_q[scan_idx].is_load &&
          !entries_q[scan_idx].ready) begin
        ld_hit = 1'b1;
        ld_idx = scan_idx;
      end
    end

    if (sb.mem_ld_done) begin
      if (ld_hit) entries_d[ld_idx].ready = 1'b1;
      else        err_d = 1'b1;
    end

    retire_ok = sb.retire_valid && (cnt_q != '0);
    if (sb.retire_valid && (cnt_q == '0)) err_d = 1'b1;
    if (retire_ok) begin
      if (!entries_d[head_q].ready) err_d = 1'b1;
      entries_d[head_q] = '0;
      head_d = head_q + 1'b1;
    end

    avail = cnt_q - (PTR_W+1)'(retire_ok);
    if (sb.flush) begin
      if (sb.flush_cnt > avail) begin
        kill  = avail;
        err_d = 1'b1;
      end else begin
        kill = sb.flush_cnt;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      kill_idx = tail_q - PTR_W'(i + 1);
      if ((PTR_W+1)'(i) < kill) entries_d[kill_idx] = '0;
    end
    // A full-depth kill leaves the low pointer bits unchanged, which is the correct wrap.
    tail_d = tail_q - kill[PTR_W-1:0];

    // Issue never coincides with flush, so the tail slot cannot also be a killed slot.
    if (issue) begin
      entries_d[tail_q] = new_entry;
      tail_d = tail_q + 1'b1;
    end

    cnt_d = cnt_q + (PTR_W+1)'(issue) - (PTR_W+1)'(retire_ok) - kill;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.id_stall     = stall;
  assign sb.id_issue     = issue;
  assign sb.inflight_cnt = cnt_q;
  assign sb.sb_full      = full;
  assign sb.sb_empty     = (cnt_q == '0);
  assign sb.sb_err       = err_q;

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign sb.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected outputs are queued per step and
// compared just after the inputs settle, away from the clock edge.
module tb_issue_scoreboard;

  logic clk;
  logic rst;

  issue_scoreboard_if #(.DEPTH(4)) sb_if ();

  issue_scoreboard #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       stall;
    logic       issue;
    int         cnt;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    sb_if.id_valid     = 1'b0;
    sb_if.id_rs1       = 5'd0;
    sb_if.id_rs2       = 5'd0;
    sb_if.id_use_rs1   = 1'b0;
    sb_if.id_use_rs2   = 1'b0;
    sb_if.id_rd        = 5'd0;
    sb_if.id_reg_write = 1'b0;
    sb_if.id_is_load   = 1'b0;
    sb_if.mem_ld_done  = 1'b0;
    sb_if.retire_valid = 1'b0;
    sb_if.flush        = 1'b0;
    sb_if.flush_cnt    = '0;
  endtask

  task automatic ins(logic [4:0] rd, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                     logic regw, logic ld);
    sb_if.id_valid     = 1'b1;
    sb_if.id_rd        = rd;
    sb_if.id_rs1       = rs1;
    sb_if.id_use_rs1   = u1;
    sb_if.id_rs2       = rs2;
    sb_if.id_use_rs2   = u2;
    sb_if.id_reg_write = regw;
    sb_if.id_is_load   = ld;
  endtask

  task automatic push_exp(string tag, logic stall, logic issue, int cnt, logic full,
                          logic empty, logic err);
    exp_t e;
    e.tag = tag; e.stall = stall; e.issue = issue; e.cnt = cnt;
    e.full = full; e.empty = empty; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic check_pending();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({e.tag, ".stall"}, 32'(sb_if.id_stall),     32'(e.stall));
      cmp({e.tag, ".issue"}, 32'(sb_if.id_issue),     32'(e.issue));
      cmp({e.tag, ".cnt"},   32'(sb_if.inflight_cnt), e.cnt);
      cmp({e.tag, ".full"},  32'(sb_if.sb_full),      32'(e.full));
      cmp({e.tag, ".empty"}, 32'(sb_if.sb_empty),     32'(e.empty));
      cmp({e.tag, ".err"},   32'(sb_if.sb_err),       32'(e.err));
    end
  endtask

  // Inputs are already driven at a negedge; check, then advance one clock.
  task automatic cyc(string tag, logic stall, logic issue, int cnt, logic full,
                     logic empty, logic err);
    push_exp(tag, stall, issue, cnt, full, empty, err);
    #1;
    check_pending();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset(string tag);
    idle();
    rst = 1'b0;
    push_exp(tag, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    #1;
    check_pending();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    push_exp("reset", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    check_pending();
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back ALU dependency forwards without stalling.
    ins(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0); cyc("add_x5", 0, 1, 0, 0, 1, 0);
    ins(5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0); cyc("add_x6", 0, 1, 1, 0, 0, 0);
    sb_if.retire_valid = 1'b1;                     cyc("ret_a",  0, 0, 2, 0, 0, 0);
    sb_if.retire_valid = 1'b1;                     cyc("ret_b",  0, 0, 1, 0, 0, 0);

    // Load-use stall until the load data arrives.
    ins(5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1); cyc("lw_x5",  0, 1, 0, 0, 1, 0);
    ins(5'd9, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc("lu_st1", 1, 0, 1, 0, 0, 0);
    ins(5'd9, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); cyc("lu_st2", 1, 0, 1, 0, 0, 0);
    ins(5'd9, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    sb_if.mem_ld_done = 1'b1;                      cyc("lu_st3", 1, 0, 1, 0, 0, 0);
    ins(5'd9, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc("lu_go",  0, 1, 1, 0, 0, 0);
    sb_if.retire_valid = 1'b1;                     cyc("ret_c",  0, 0, 2, 0, 0, 0);
    sb_if.retire_valid = 1'b1;                     cyc("ret_d",  0, 0, 1, 0, 0, 0);

    // Youngest writer of x7 is a ready ALU op, shadowing the older load.
    ins(5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1); cyc("lw_x7",  0, 1, 0, 0, 1, 0);
    ins(5'd7, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc("addi7",  0, 1, 1, 0, 0, 0);
    ins(5'd10, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc("use_x7", 0, 1, 2, 0, 0, 0);

    // Fill the queue; the fifth stalls on full even with a same-cycle retire.
    ins(5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    sb_if.mem_ld_done = 1'b1;                      cyc("fill4",  0, 1, 3, 0, 0, 0);
    ins(5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    sb_if.retire_valid = 1'b1;                     cyc("full_st", 1, 0, 4, 1, 0, 0);
    ins(5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("fifth",  0, 1, 3, 0, 0, 0);
    cyc("full_again", 0, 0, 4, 1, 0, 0);
    sb_if.flush = 1'b1; sb_if.flush_cnt = 3'd4;    cyc("flush4", 0, 0, 4, 1, 0, 0);
    cyc("flushed", 0, 0, 0, 0, 1, 0);

    // Flush kills the unready load, so its consumer then issues freely.
    ins(5'd13, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("i_a",   0, 1, 0, 0, 1, 0);
    ins(5'd14, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("i_b",   0, 1, 1, 0, 0, 0);
    ins(5'd8, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);  cyc("lw_x8", 0, 1, 2, 0, 0, 0);
    ins(5'd15, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    sb_if.flush = 1'b1; sb_if.flush_cnt = 3'd1;    cyc("flush1", 1, 0, 3, 0, 0, 0);
    ins(5'd15, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc("use_x8", 0, 1, 2, 0, 0, 0);
    sb_if.retire_valid = 1'b1;
    sb_if.flush = 1'b1; sb_if.flush_cnt = 3'd2;    cyc("ret_flush", 0, 0, 3, 0, 0, 0);
    cyc("drained", 0, 0, 0, 0, 1, 0);

    // Retire on empty raises the sticky error.
    sb_if.retire_valid = 1'b1;                     cyc("ret_empty", 0, 0, 0, 0, 1, 0);
    cyc("err_set", 0, 0, 0, 0, 1, 1);
    ins(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("err_sticky", 0, 1, 0, 0, 1, 1);
    sb_if.id_valid = 1'b0;
    do_reset("mid_reset");

    // Load completion with nothing pending.
    sb_if.mem_ld_done = 1'b1;                      cyc("ld_orphan", 0, 0, 0, 0, 1, 0);
    cyc("ld_orphan_err", 0, 0, 0, 0, 1, 1);
    do_reset("reset2");

    // Retiring a load whose data never arrived.
    ins(5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("lw_x4", 0, 1, 0, 0, 1, 0);
    sb_if.retire_valid = 1'b1;                     cyc("ret_unrdy", 0, 0, 1, 0, 0, 0);
    cyc("unrdy_err", 0, 0, 0, 0, 1, 1);
    do_reset("reset3");

    // Over-long flush is clamped to the occupancy.
    ins(5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("add_x4", 0, 1, 0, 0, 1, 0);
    sb_if.flush = 1'b1; sb_if.flush_cnt = 3'd2;    cyc("flush_over", 0, 0, 1, 0, 0, 0);
    cyc("clamp_err", 0, 0, 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
